arcade_input_mapper: RTL and testbench



---
 rtl/arcade_input_pkg.sv | 33 +++
 rtl/coin_pulse_shaper.sv | 41 ++++
 rtl/arcade_input_mapper.sv | 80 ++++++++
 tb/tb_arcade_input_mapper.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: joystick bit layout, keyboard scan-code maps and shared enums for arcade_input_mapper
package arcade_input_pkg;
  localparam int BIT_RIGHT = 0;
  localparam int BIT_LEFT = 1;
  localparam int BIT_DOWN = 2;
  localparam int BIT_UP = 3;
  localparam int BIT_BTN0 = 4;
  localparam int MAP_LEN = 11;
  localparam logic [7:0] SC_P0_UP = 8'h75, SC_P0_DOWN = 8'h72, SC_P0_LEFT = 8'h6B, SC_P0_RIGHT = 8'h74;
  localparam logic [7:0] SC_P0_BTN0 = 8'h14, SC_P0_BTN1 = 8'h11, SC_P0_BTN2 = 8'h29, SC_P0_BTN3 = 8'h12;
  localparam logic [7:0] SC_P0_START = 8'h05, SC_P0_START_ALT = 8'h16, SC_P0_COIN = 8'h2E;
  localparam logic [7:0] SC_P1_UP = 8'h2D, SC_P1_DOWN = 8'h2B, SC_P1_LEFT = 8'h23, SC_P1_RIGHT = 8'h34;
  localparam logic [7:0] SC_P1_BTN0 = 8'h1C, SC_P1_BTN1 = 8'h1B, SC_P1_BTN2 = 8'h15, SC_P1_BTN3 = 8'h1D;
  localparam logic [7:0] SC_P1_START = 8'h06, SC_P1_START_ALT = 8'h1E, SC_P1_COIN = 8'h36;
  // Entry i: 0..3 directions in joystick bit order, 4..7 buttons, 8/9 start, 10 coin
  localparam logic [1:0][MAP_LEN-1:0][7:0] KEYMAP = {
    SC_P1_COIN, SC_P1_START_ALT, SC_P1_START, SC_P1_BTN3, SC_P1_BTN2, SC_P1_BTN1, SC_P1_BTN0,
    SC_P1_UP, SC_P1_DOWN, SC_P1_LEFT, SC_P1_RIGHT,
    SC_P0_COIN, SC_P0_START_ALT, SC_P0_START, SC_P0_BTN3, SC_P0_BTN2, SC_P0_BTN1, SC_P0_BTN0,
    SC_P0_UP, SC_P0_DOWN, SC_P0_LEFT, SC_P0_RIGHT};
  typedef enum logic [1:0] {DB15_OFF = 2'b00, DB15_ONE = 2'b01, DB15_TWO = 2'b10} db15_mode_e;
  typedef enum logic [1:0] {CS_IDLE, CS_PULSE, CS_GAP, CS_WAIT_REL} coin_state_e;
  function automatic int key_index(input int player, input logic [7:0] code, input int buttons);
    int idx;
    idx = -1;
    if (player < 2)
      for (int i = 0; i < MAP_LEN; i++)
        if (KEYMAP[player[0]][i[3:0]] == code)
          idx = i <= BIT_UP ? i : i < BIT_BTN0 + 4 ? (i - BIT_BTN0 < buttons ? i : -1) :
                i < MAP_LEN - 1 ? buttons + 4 : buttons + 5;
    return idx;
  endfunction
endpackage

// File: rtl/coin_pulse_shaper.sv
// coin_pulse_shaper: turns a raw coin level into one fixed-width pulse followed by a guaranteed low gap
module coin_pulse_shaper #(
  parameter int PULSE_CYC = 2500000,
  parameter int GAP_CYC = 1250000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic coin_raw,
  output logic coin_out
);
  import arcade_input_pkg::*;
  localparam int CW = $clog2((PULSE_CYC > GAP_CYC ? PULSE_CYC : GAP_CYC) + 1);
  coin_state_e state;
  logic [CW-1:0] cnt;
  logic raw_q;
  // raw_q keeps tracking through reset so a held coin is not seen as a new edge afterwards
  always_ff @(posedge clk_sys) begin
    raw_q <= coin_raw;
    if (reset) begin
      state <= CS_IDLE;
      cnt <= '0;
      coin_out <= 1'b0;
    end else begin
      case (state)
        CS_IDLE: if (coin_raw && !raw_q) begin
          state <= CS_PULSE;
          cnt <= CW'(PULSE_CYC - 1);
          coin_out <= 1'b1;
        end
        CS_PULSE: if (cnt == '0) begin
          state <= CS_GAP;
          cnt <= CW'(GAP_CYC - 1);
          coin_out <= 1'b0;
        end else cnt <= cnt - 1'b1;
        CS_GAP: if (cnt == '0) state <= coin_raw ? CS_WAIT_REL : CS_IDLE;
          else cnt <= cnt - 1'b1;
        default: if (!coin_raw) state <= CS_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: merges USB/DB15/PS2 controls per player, shapes coins, captures HPS DIP banks.
// SNAC_DB15_EN enables merging of the two DB15 ports.
module arcade_input_mapper #(
  parameter int PLAYERS = 2,
  parameter int BUTTONS = 4,
  parameter int DIP_BANKS = 8,
  parameter int COIN_PULSE_CYC = 2500000,
  parameter int COIN_GAP_CYC = 1250000
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  input  logic [10:0]                     ps2_key,
  input  logic [PLAYERS*16-1:0]           joy_usb,
  input  logic [31:0]                     joy_db15,
  input  logic [1:0]                      db15_mode,
  input  logic                            ioctl_wr,
  input  logic [7:0]                      ioctl_index,
  input  logic [24:0]                     ioctl_addr,
  input  logic [7:0]                      ioctl_dout,
  output logic [PLAYERS*(BUTTONS+6)-1:0]  player_out,
  output logic [BUTTONS+5:0]              any_out,
  output logic [DIP_BANKS*8-1:0]          dip,
  output logic                            dip_valid
);
  import arcade_input_pkg::*;
  localparam int W = BUTTONS + 6;
  logic [PLAYERS-1:0][W-1:0] joy_m, key_q;
  logic [PLAYERS-1:0][W-2:0] ctl_q;
  logic [PLAYERS-1:0] coin_q;
  logic tog_q;
  logic [DIP_BANKS-1:0][7:0] dip_q = '0;
  logic dip_valid_q = 1'b0;
  logic unused;
  assign unused = ^{ps2_key[8], joy_usb, joy_db15, db15_mode};
  always_comb begin
    joy_m = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      joy_m[p] = joy_usb[16*p +: W];
`ifdef SNAC_DB15_EN
      if (p == 0 && db15_mode != DB15_OFF) joy_m[p] = joy_m[p] | joy_db15[W-1:0];
      if (p == 1 && db15_mode[1]) joy_m[p] = joy_m[p] | joy_db15[16 +: W];
`endif
    end
  end
  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[10];
    if (reset) key_q <= '0;
    else if (ps2_key[10] != tog_q)
      for (int p = 0; p < PLAYERS; p++)
        for (int i = 0; i < W; i++)
          if (i == key_index(p, ps2_key[7:0], BUTTONS)) key_q[p][i] <= ps2_key[9];
  end
  always_ff @(posedge clk_sys) begin
    if (reset) ctl_q <= '0;
    else for (int p = 0; p < PLAYERS; p++) ctl_q[p] <= joy_m[p][W-2:0] | key_q[p][W-2:0];
  end
  for (genvar g = 0; g < PLAYERS; g++) begin : g_ply
    coin_pulse_shaper #(.PULSE_CYC(COIN_PULSE_CYC), .GAP_CYC(COIN_GAP_CYC)) u_coin (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .coin_raw (joy_m[g][W-1] | key_q[g][W-1]),
      .coin_out (coin_q[g])
    );
    assign player_out[g*W +: W] = {coin_q[g], ctl_q[g]};
  end
  always_comb begin
    any_out = '0;
    for (int p = 0; p < PLAYERS; p++) any_out = any_out | player_out[p*W +: W];
  end
  // DIP banks deliberately ignore reset so settings survive OSD reset and ROM reloads
  always_ff @(posedge clk_sys) begin
    if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == '0 && int'(ioctl_addr[2:0]) < DIP_BANKS) begin
      dip_valid_q <= 1'b1;
      for (int b = 0; b < DIP_BANKS; b++)
        if (b == int'(ioctl_addr[2:0])) dip_q[b] <= ioctl_dout;
    end
  end
  assign dip = dip_q;
  assign dip_valid = dip_valid_q;
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed checks of merge, keyboard, coin shaping, DB15 and DIP capture
module tb_arcade_input_mapper;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [31:0] joy_usb, joy_db15;
  logic [1:0]  db15_mode;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic [19:0] player_out;
  logic [9:0]  any_out;
  logic [63:0] dip;
  logic        dip_valid;
  int errors = 0, checks = 0, hi;
  logic tog = 1'b0;
  logic [19:0] e_two, e_one;

  arcade_input_mapper #(
    .PLAYERS(2), .BUTTONS(4), .DIP_BANKS(8), .COIN_PULSE_CYC(8), .COIN_GAP_CYC(4)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_usb(joy_usb), .joy_db15(joy_db15),
    .db15_mode(db15_mode), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .player_out(player_out), .any_out(any_out), .dip(dip), .dip_valid(dip_valid)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic key(input logic pressed, input logic [7:0] code);
    tog = ~tog;
    ps2_key = {tog, pressed, 1'b0, code};
  endtask

  initial begin
`ifdef SNAC_DB15_EN
    e_two = 20'h04000;
    e_one = 20'h00001;
`else
    e_two = 20'h0;
    e_one = 20'h0;
`endif
    reset = 1'b1; ps2_key = '0; joy_usb = '0; joy_db15 = '0; db15_mode = 2'b00;
    ioctl_wr = 1'b0; ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
    tick(3);
    chk("rst_player", player_out, 0);
    chk("rst_any", any_out, 0);
    chk("pwr_dip", dip, 0);
    chk("pwr_dip_valid", dip_valid, 0);
    reset = 1'b0;
    tick();
    joy_usb = 32'h8;
    tick();
    chk("joy_up", player_out, 20'h8);
    chk("any_up", any_out, 10'h8);
    joy_usb = '0;
    tick();
    chk("joy_rel", player_out, 0);
    joy_usb = 32'h0010_0100;
    tick();
    chk("joy_mix", player_out, 20'h04100);
    chk("any_mix", any_out, 10'h110);
    joy_usb = '0;
    tick();
    key(1'b1, 8'h6B);
    tick();
    chk("kbd_latch_stage", player_out, 0);
    tick();
    chk("kbd_left", player_out, 20'h2);
    key(1'b0, 8'h6B);
    tick();
    chk("kbd_left_hold", player_out, 20'h2);
    tick();
    chk("kbd_left_rel", player_out, 0);
    key(1'b1, 8'h5A);
    tick(2);
    chk("kbd_unmapped", player_out, 0);
    key(1'b1, 8'h1C);
    tick(2);
    chk("kbd_p1_btn0", player_out, 20'h04000);
    key(1'b0, 8'h1C);
    tick(2);
    chk("kbd_p1_rel", player_out, 0);
    key(1'b1, 8'h16);
    joy_usb = 32'h8;
    tick();
    chk("same_cyc_joy", player_out, 20'h8);
    tick();
    chk("same_cyc_both", player_out, 20'h108);
    key(1'b0, 8'h16);
    joy_usb = '0;
    tick(2);
    chk("same_cyc_rel", player_out, 0);
    joy_usb = 32'h200;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("coin_hold", player_out, i <= 8 ? 20'h200 : 20'h0);
    end
    joy_usb = '0;
    tick(6);
    joy_usb = 32'h200;
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk("coin_again", player_out, i <= 8 ? 20'h200 : 20'h0);
    end
    joy_usb = '0;
    tick(6);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      joy_usb = (i == 0 || i == 2) ? 32'h200 : 32'h0;
      tick();
      if (player_out[9]) hi++;
    end
    chk("coin_drop_edge", hi, 8);
    key(1'b1, 8'h14);
    tick(2);
    chk("kbd_p0_btn0", player_out, 20'h10);
    joy_usb = 32'h200;
    tick(3);
    chk("coin_mid", player_out, 20'h210);
    reset = 1'b1;
    tick();
    chk("rst_mid_pulse", player_out, 0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rst_coin_held", player_out, 0);
    end
    joy_usb = '0;
    tick(2);
    db15_mode = 2'b10;
    joy_db15 = 32'h0010_0000;
    tick();
    chk("db15_two", player_out, e_two);
    db15_mode = 2'b00;
    tick();
    chk("db15_off", player_out, 0);
    db15_mode = 2'b01;
    joy_db15 = 32'h0010_0001;
    tick();
    chk("db15_one", player_out, e_one);
    db15_mode = 2'b00;
    joy_db15 = '0;
    tick();
    for (int a = 0; a < 8; a++) begin
      ioctl_wr = 1'b1;
      ioctl_index = 8'd254;
      ioctl_addr = 25'(a);
      ioctl_dout = 8'hA0 + 8'(a);
      tick();
      if (a == 0) begin
        chk("dip_valid_set", dip_valid, 1);
        chk("dip_bank0", dip[7:0], 8'hA0);
      end
    end
    ioctl_wr = 1'b0;
    tick();
    chk("dip_all", dip, 64'hA7A6A5A4A3A2A1A0);
    ioctl_wr = 1'b1;
    ioctl_index = 8'd1;
    ioctl_addr = 25'd0;
    ioctl_dout = 8'hFF;
    tick();
    ioctl_index = 8'd254;
    ioctl_addr = 25'd8;
    tick();
    ioctl_wr = 1'b0;
    tick();
    chk("dip_ignored", dip, 64'hA7A6A5A4A3A2A1A0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
    chk("dip_after_rst", dip, 64'hA7A6A5A4A3A2A1A0);
    chk("dip_valid_rst", dip_valid, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
